// File: rtl/flot2fxd_seq.sv
// flot2fxd_seq: iterative float32 to sign-magnitude fixed-point converter; define ROUND_NEAREST_EN for round-half-to-even, else truncate
module flot2fxd_seq #(
  parameter int FXD_W = 19,
  parameter int MAN_W = 23,
  parameter int EXP_W = 8
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   in_vld,
  output logic                   in_rdy,
  input  logic [EXP_W+MAN_W:0]   in_flt,
  output logic                   out_vld,
  input  logic                   out_rdy,
  output logic [FXD_W-1:0]       out_fxd,
  output logic                   out_zro,
  output logic                   out_ovf,
  output logic                   out_nan
);
  localparam int BIAS = 2**(EXP_W-1)-1;
  localparam int MW = FXD_W-1;
  localparam int KW = $clog2(MAN_W+2);
  localparam logic [EXP_W-1:0] E_OVF = EXP_W'(BIAS+MW);
  localparam logic [EXP_W-1:0] E_LOW = EXP_W'(BIAS-2);
  localparam logic [EXP_W-1:0] E_K = EXP_W'(BIAS+MAN_W);
  typedef enum logic [1:0] {IDLE, SHIFT, RND, HOLD} state_t;
  state_t state, nxt;
  logic s, g, stk, inc, ovf;
  logic [MAN_W:0] sig;
  logic [KW-1:0] k;
  logic [MAN_W+1:0] mag;
  logic [MW-1:0] sat;
  logic fs, is_top, is_nan, is_big, is_small;
  logic [EXP_W-1:0] fe;
  logic [MAN_W-1:0] fm;
  assign {fs, fe, fm} = in_flt;
  assign is_top = fe == '1;
  assign is_nan = is_top && fm != '0;
  assign is_big = is_top || fe >= E_OVF;
  assign is_small = fe <= E_LOW;
  assign in_rdy = state == IDLE;
  assign out_vld = state == HOLD;
`ifdef ROUND_NEAREST_EN
  assign inc = g & (stk | sig[0]);
`else
  assign inc = 1'b0;
`endif
  assign mag = {1'b0, sig} + (MAN_W+2)'(inc);
  assign ovf = |mag[MAN_W+1:MW];
  assign sat = ovf ? '1 : mag[MW-1:0];
  // state register; async reset abandons any in-flight item
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) state <= IDLE;
    else state <= nxt;
  // next-state: specials skip straight to HOLD, normals shift k times then round
  always_comb begin
    nxt = state;
    case (state)
      IDLE:  if (in_vld) nxt = (is_big || is_small) ? HOLD : SHIFT;
      SHIFT: if (k == KW'(1)) nxt = RND;
      RND:   nxt = HOLD;
      HOLD:  if (out_rdy) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  // datapath: latch at accept, shift with guard/sticky, register rounded result
  always_ff @(posedge wb_clk_i or posedge wb_rst_i)
    if (wb_rst_i) begin
      s <= 1'b0;
      sig <= '0;
      g <= 1'b0;
      stk <= 1'b0;
      k <= '0;
      out_fxd <= '0;
      out_zro <= 1'b0;
      out_ovf <= 1'b0;
      out_nan <= 1'b0;
    end else if (state == IDLE && in_vld) begin
      s <= fs;
      sig <= {1'b1, fm};
      g <= 1'b0;
      stk <= 1'b0;
      k <= KW'(E_K - fe);
      if (is_nan) begin
        out_fxd <= '0;
        out_zro <= 1'b1;
        out_ovf <= 1'b0;
        out_nan <= 1'b1;
      end else if (is_big) begin
        out_fxd <= {fs, {MW{1'b1}}};
        out_zro <= 1'b0;
        out_ovf <= 1'b1;
        out_nan <= 1'b0;
      end else if (is_small) begin
        out_fxd <= '0;
        out_zro <= 1'b1;
        out_ovf <= 1'b0;
        out_nan <= 1'b0;
      end
    end else if (state == SHIFT) begin
      sig <= sig >> 1;
      g <= sig[0];
      stk <= stk | g;
      k <= k - KW'(1);
    end else if (state == RND) begin
      out_fxd <= (mag == '0) ? '0 : {s, sat};
      out_zro <= mag == '0;
      out_ovf <= ovf;
      out_nan <= 1'b0;
    end
endmodule

// File: tb/tb_flot2fxd_seq.sv
// tb_flot2fxd_seq: directed self-checking bench for flot2fxd_seq
module tb_flot2fxd_seq;
  logic clk = 1'b0, rst = 1'b1, in_vld = 1'b0, out_rdy = 1'b1;
  logic in_rdy, out_vld, out_zro, out_ovf, out_nan;
  logic [31:0] in_flt = '0;
  logic [18:0] out_fxd;
  int checks = 0, failures = 0;
`ifdef ROUND_NEAREST_EN
  localparam logic [18:0] R15 = 19'd2, R075 = 19'd1;
  localparam logic Z075 = 1'b0;
`else
  localparam logic [18:0] R15 = 19'd1, R075 = 19'd0;
  localparam logic Z075 = 1'b1;
`endif
  flot2fxd_seq dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .in_vld(in_vld), .in_rdy(in_rdy), .in_flt(in_flt),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_fxd(out_fxd), .out_zro(out_zro),
    .out_ovf(out_ovf), .out_nan(out_nan)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic send(input logic [31:0] f);
    int n = 0;
    while (!in_rdy && n < 100) begin @(posedge clk); #1; n++; end
    chk("send_rdy", {31'b0, in_rdy}, 32'd1);
    in_flt = f;
    in_vld = 1'b1;
    @(posedge clk); #1;
    in_vld = 1'b0;
    in_flt = $urandom;
  endtask
  task automatic wait_out(output int n);
    n = 1;
    while (!out_vld && n < 100) begin @(posedge clk); #1; n++; end
  endtask
  task automatic conv(input string tag, input logic [31:0] f, input logic [18:0] fxd,
                      input logic zro, input logic ovf, input logic nan, input int lat);
    int n;
    send(f);
    wait_out(n);
    chk({tag, "_vld"}, {31'b0, out_vld}, 32'd1);
    chk({tag, "_lat"}, n, lat);
    chk({tag, "_fxd"}, {13'b0, out_fxd}, {13'b0, fxd});
    chk({tag, "_flags"}, {29'b0, out_zro, out_ovf, out_nan}, {29'b0, zro, ovf, nan});
    @(posedge clk); #1;
  endtask
  initial begin
    int n;
    #1;
    chk("rst_rdy", {31'b0, in_rdy}, 32'd1);
    chk("rst_vld", {31'b0, out_vld}, 32'd0);
    chk("rst_out", {10'b0, out_fxd, out_zro, out_ovf, out_nan}, 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    conv("one", 32'h3F800000, 19'h00001, 0, 0, 0, 25);
    conv("neg_min", 32'hC8000000, 19'h60000, 0, 0, 0, 8);
    conv("max", 32'h47FFFF80, 19'h1FFFF, 0, 0, 0, 9);
    conv("big", 32'h48800000, 19'h3FFFF, 0, 1, 0, 1);
    conv("ninf", 32'hFF800000, 19'h7FFFF, 0, 1, 0, 1);
    conv("nan", 32'h7FC00000, 19'h0, 1, 0, 1, 1);
    conv("denorm", 32'h00000001, 19'h0, 1, 0, 0, 1);
    conv("p1_5", 32'h3FC00000, R15, 0, 0, 0, 25);
    conv("p2_5", 32'h40200000, 19'd2, 0, 0, 0, 24);
    conv("p0_5", 32'h3F000000, 19'd0, 1, 0, 0, 26);
    conv("n0_5", 32'hBF000000, 19'd0, 1, 0, 0, 26);
    conv("p0_75", 32'h3F400000, R075, Z075, 0, 0, 26);
    out_rdy = 1'b0;
    send(32'h40400000);
    wait_out(n);
    chk("bp_lat", n, 24);
    in_flt = 32'h41000000;
    in_vld = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_hold", {11'b0, out_vld, in_rdy, out_fxd}, {11'b0, 1'b1, 1'b0, 19'd3});
    end
    out_rdy = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {30'b0, out_vld, in_rdy}, 32'd1);
    @(posedge clk); #1;
    in_vld = 1'b0;
    wait_out(n);
    chk("held_lat", n, 22);
    chk("held_fxd", {13'b0, out_fxd}, 32'd8);
    @(posedge clk); #1;
    conv("b2b_a", 32'hC0E00000, 19'h40007, 0, 0, 0, 23);
    conv("b2b_b", 32'h42C80000, 19'd100, 0, 0, 0, 19);
    conv("b2b_c", 32'h40A00000, 19'd5, 0, 0, 0, 23);
    send(32'h3F800000);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("arst_vld", {31'b0, out_vld}, 32'd0);
    chk("arst_fxd", {13'b0, out_fxd}, 32'd0);
    chk("arst_rdy", {31'b0, in_rdy}, 32'd1);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    conv("after_rst", 32'h41200000, 19'd10, 0, 0, 0, 22);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
